// File: rtl/alu_pkg.sv
// Shared types, frame constants and CRC-4 helpers for the ALU serial receiver.
package alu_pkg;

  typedef enum logic [2:0] {
    AND = 3'b000,
    OR  = 3'b001,
    ADD = 3'b100,
    SUB = 3'b101
  } operation_t;

  localparam int   FRAME_BITS = 11;
  localparam logic CTL_DATA   = 1'b0;
  localparam logic CTL_CMD    = 1'b1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE, WAIT_HI} rx_state_t;

  typedef struct packed {
    logic frame;
    logic data;
    logic op;
    logic crc;
  } rx_err_t;

  // One serial step of CRC-4, x^4+x+1.
  function automatic logic [3:0] crc4_step(input logic [3:0] c, input logic b);
    logic fb;
    fb = c[3] ^ b;
    return {c[2], c[1], c[0] ^ fb, fb};
  endfunction

  function automatic logic [3:0] crc4_calc(input logic [67:0] m);
    logic [3:0] c;
    c = '0;
    for (int i = 67; i >= 0; i--) c = crc4_step(c, m[i]);
    return c;
  endfunction

  function automatic logic op_valid(input logic [2:0] op);
    return op inside {AND, OR, ADD, SUB};
  endfunction

endpackage

// File: rtl/alu_rx_crc4.sv
// Serial CRC-4 accumulator over data bytes; the marker and op bits are folded
// in combinationally at CMD time. Only built with ALU_RX_CRC_CHECK_EN.
module alu_rx_crc4
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic [7:0] byte_i,
  input  logic [2:0] op_i,
  output logic [3:0] crc_o
);

  logic [3:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    for (int i = 7; i >= 0; i--) crc_d = crc4_step(crc_d, byte_i[i]);
  end

  always_comb begin
    crc_o = crc4_step(crc_q, 1'b1);
    for (int i = 2; i >= 0; i--) crc_o = crc4_step(crc_o, op_i[i]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clr_i) crc_q <= '0;
    else if (en_i)       crc_q <= crc_d;
  end

endmodule

// File: rtl/alu_serial_rx.sv
// Serial command deserializer for the ALU core: 8 data frames then one CMD frame.
// Define ALU_RX_CRC_CHECK_EN to build the CRC-4 checker; otherwise err_crc is 0.
module alu_serial_rx
  import alu_pkg::*;
#(
  parameter int DW             = 32,
  parameter int NUM_DATA_BYTES = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          sin,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_a,
  output logic [DW-1:0] out_b,
  output logic [2:0]    out_op,
  output logic [3:0]    out_crc,
  output logic          err_frame,
  output logic          err_data,
  output logic          err_op,
  output logic          err_crc,
  output logic          overrun
);

  localparam int            BAW      = NUM_DATA_BYTES * 8;
  localparam int            CW       = $clog2(NUM_DATA_BYTES + 1);
  localparam logic [CW-1:0] NDB      = CW'(NUM_DATA_BYTES);
  localparam logic [3:0]    STOP_IDX = 4'(FRAME_BITS - 2);

  rx_state_t      state_q, state_d;
  logic [3:0]     bit_cnt_q, bit_cnt_d;
  logic [9:0]     sh_q, sh_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           many_q, many_d;
  logic [BAW-1:0] ba_q, ba_d;
  logic           vld_q, vld_d, ovr_q, ovr_d;
  logic [DW-1:0]  a_q, a_d, b_q, b_d;
  logic [2:0]     op_q, op_d;
  logic [3:0]     crc_q, crc_d;
  rx_err_t        err_q, err_d;

  logic           emit;
  logic [DW-1:0]  na, nb;
  logic [2:0]     nop;
  logic [3:0]     ncrc;
  rx_err_t        nerr;

  // After 10 shifts: sh_q = {ctl, d7..d0, stop}
  logic       rx_ctl, rx_stop, data_ok, crc_bad;
  logic [7:0] rx_byte;
  assign rx_ctl  = sh_q[9];
  assign rx_byte = sh_q[8:1];
  assign rx_stop = sh_q[0];
  assign data_ok = (cnt_q == NDB) && !many_q;

`ifdef ALU_RX_CRC_CHECK_EN
  logic [3:0] crc_calc;
  logic       crc_clr, crc_en;
  assign crc_clr = (state_q == DONE) && (!rx_stop || rx_ctl == CTL_CMD);
  assign crc_en  = (state_q == DONE) && rx_stop && rx_ctl == CTL_DATA && cnt_q != NDB;

  alu_rx_crc4 u_crc (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (crc_clr),
    .en_i   (crc_en),
    .byte_i (rx_byte),
    .op_i   (rx_byte[6:4]),
    .crc_o  (crc_calc)
  );
  assign crc_bad = data_ok && (crc_calc != rx_byte[3:0]);
`else
  assign crc_bad = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    sh_d      = sh_q;
    cnt_d     = cnt_q;
    many_d    = many_q;
    ba_d      = ba_q;
    vld_d     = vld_q;
    ovr_d     = ovr_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    crc_d     = crc_q;
    err_d     = err_q;
    emit      = 1'b0;
    na        = '0;
    nb        = '0;
    nop       = '0;
    ncrc      = '0;
    nerr      = '0;

    if (vld_q && out_ready) vld_d = 1'b0;

    unique case (state_q)
      IDLE: if (!sin) begin
        state_d   = SHIFT;
        bit_cnt_d = '0;
      end
      SHIFT: begin
        sh_d      = {sh_q[8:0], sin};
        bit_cnt_d = bit_cnt_q + 4'd1;
        if (bit_cnt_q == STOP_IDX) state_d = DONE;
      end
      DONE: begin
        if (!rx_stop) begin
          state_d    = WAIT_HI;
          emit       = 1'b1;
          nerr.frame = 1'b1;
          cnt_d      = '0;
          many_d     = 1'b0;
          ba_d       = '0;
        end else begin
          state_d = IDLE;
          if (rx_ctl == CTL_DATA) begin
            if (cnt_q == NDB) many_d = 1'b1;
            else begin
              ba_d  = {ba_q[BAW-9:0], rx_byte};
              cnt_d = cnt_q + 1'b1;
            end
          end else begin
            emit      = 1'b1;
            nop       = rx_byte[6:4];
            ncrc      = rx_byte[3:0];
            nerr.data = !data_ok;
            nerr.op   = !op_valid(rx_byte[6:4]);
            nerr.crc  = crc_bad;
            if (data_ok) begin
              na = ba_q[DW-1:0];
              nb = ba_q[BAW-1 -: DW];
            end
            cnt_d  = '0;
            many_d = 1'b0;
            ba_d   = '0;
          end
        end
      end
      WAIT_HI: if (sin) state_d = IDLE;
    endcase

    // A still-unaccepted packet wins; the newcomer is dropped and flagged.
    if (emit) begin
      if (vld_q && !out_ready) ovr_d = 1'b1;
      else begin
        vld_d = 1'b1;
        a_d   = na;
        b_d   = nb;
        op_d  = nop;
        crc_d = ncrc;
        err_d = nerr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= WAIT_HI;
      bit_cnt_q <= '0;
      sh_q      <= '0;
      cnt_q     <= '0;
      many_q    <= 1'b0;
      ba_q      <= '0;
      vld_q     <= 1'b0;
      ovr_q     <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      crc_q     <= '0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      sh_q      <= sh_d;
      cnt_q     <= cnt_d;
      many_q    <= many_d;
      ba_q      <= ba_d;
      vld_q     <= vld_d;
      ovr_q     <= ovr_d;
      a_q       <= a_d;
      b_q       <= b_d;
      op_q      <= op_d;
      crc_q     <= crc_d;
      err_q     <= err_d;
    end
  end

  assign out_valid = vld_q;
  assign out_a     = a_q;
  assign out_b     = b_q;
  assign out_op    = op_q;
  assign out_crc   = crc_q;
  assign err_frame = err_q.frame;
  assign err_data  = err_q.data;
  assign err_op    = err_q.op;
  assign err_crc   = err_q.crc;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_alu_serial_rx.sv
// Directed + randomized bench for alu_serial_rx with a packet-level reference model.
module tb_alu_serial_rx;

  logic        clk = 1'b0;
  logic        rst_n, sin, out_ready;
  logic        out_valid, err_frame, err_data, err_op, err_crc, overrun;
  logic [31:0] out_a, out_b;
  logic [2:0]  out_op;
  logic [3:0]  out_crc;

  int checks = 0;
  int errors = 0;

  logic [7:0]  dq[$];
  logic [31:0] e_a, e_b;
  logic [2:0]  e_op;
  logic [3:0]  e_crc, e_err;
  logic [31:0] h_a, h_b;
  logic [2:0]  h_op;
  logic [3:0]  h_crc, h_err;

  alu_serial_rx dut (
    .clk(clk), .rst_n(rst_n), .sin(sin), .out_ready(out_ready),
    .out_valid(out_valid), .out_a(out_a), .out_b(out_b), .out_op(out_op),
    .out_crc(out_crc), .err_frame(err_frame), .err_data(err_data),
    .err_op(err_op), .err_crc(err_crc), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Remainder of M(x)*x^4 divided by x^4+x+1.
  function automatic logic [3:0] crc_ref(input logic [67:0] m);
    logic [71:0] r;
    r = {m, 4'b0};
    for (int i = 71; i >= 4; i--) if (r[i]) r[i -: 5] = r[i -: 5] ^ 5'b10011;
    return r[3:0];
  endfunction

  function automatic logic [3:0] good_crc(input logic [2:0] op);
    return crc_ref({dq[0], dq[1], dq[2], dq[3], dq[4], dq[5], dq[6], dq[7], 1'b1, op});
  endfunction

  task automatic expect_pkt(input logic [2:0] op, input logic [3:0] crc);
    logic ok, eo, ec;
    ok  = (dq.size() == 8);
    e_b = ok ? {dq[0], dq[1], dq[2], dq[3]} : 32'h0;
    e_a = ok ? {dq[4], dq[5], dq[6], dq[7]} : 32'h0;
    e_op  = op;
    e_crc = crc;
    eo = !(op == 3'b000 || op == 3'b001 || op == 3'b100 || op == 3'b101);
`ifdef ALU_RX_CRC_CHECK_EN
    ec = ok && (crc != good_crc(op));
`else
    ec = 1'b0;
`endif
    e_err = {1'b0, !ok, eo, ec};
  endtask

  task automatic drive_bit(input logic b);
    @(posedge clk);
    #1 sin = b;
  endtask

  task automatic send_frame(input logic ctl, input logic [7:0] d, input logic stop);
    drive_bit(1'b0);
    drive_bit(ctl);
    for (int i = 7; i >= 0; i--) drive_bit(d[i]);
    drive_bit(stop);
  endtask

  task automatic send_data;
    foreach (dq[i]) begin
      send_frame(1'b0, dq[i], 1'b1);
      drive_bit(1'b1);
      drive_bit(1'b1);
    end
  endtask

  task automatic send_pkt(input logic [2:0] op, input logic [3:0] crc);
    send_data();
    send_frame(1'b1, {1'b0, op, crc}, 1'b1);
  endtask

  // Called right after the stop bit is driven; out_valid is due on the 3rd negedge.
  task automatic check_pkt(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 10);
    chk({tag, " latency"}, 64'(n), 64'd3);
    chk({tag, " a"}, 64'(out_a), 64'(e_a));
    chk({tag, " b"}, 64'(out_b), 64'(e_b));
    chk({tag, " op"}, 64'(out_op), 64'(e_op));
    chk({tag, " crc"}, 64'(out_crc), 64'(e_crc));
    chk({tag, " errs"}, 64'({err_frame, err_data, err_op, err_crc}), 64'(e_err));
    if (out_ready) begin
      @(negedge clk);
      chk({tag, " drop"}, 64'(out_valid), 64'd0);
    end
  endtask

  task automatic fill_random(input int n);
    dq.delete();
    for (int i = 0; i < n; i++) dq.push_back(8'($urandom));
  endtask

  task automatic check_zero(input string tag);
    chk(tag, {out_valid, out_a, out_b, out_op, out_crc, err_frame, err_data, err_op,
              err_crc, overrun}, 64'h0);
  endtask

  initial begin
    logic [2:0] op;
    logic [3:0] crc;
    int n;

    rst_n = 1'b0; sin = 1'b1; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    drive_bit(1'b1);

    // Nominal B=3, A=5, ADD
    dq = '{8'h00, 8'h00, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00, 8'h05};
    crc = good_crc(3'b100);
    expect_pkt(3'b100, crc);
    send_pkt(3'b100, crc);
    check_pkt("nominal");

    crc = good_crc(3'b100) ^ 4'h1;
    expect_pkt(3'b100, crc);
    send_pkt(3'b100, crc);
    check_pkt("crc_err");

    fill_random(7);
    expect_pkt(3'b000, 4'h3);
    send_pkt(3'b000, 4'h3);
    check_pkt("short");

    fill_random(9);
    expect_pkt(3'b001, 4'hA);
    send_pkt(3'b001, 4'hA);
    check_pkt("long");

    // Frame error on a data byte, then a clean packet
    send_frame(1'b0, 8'h5A, 1'b0);
    e_a = '0; e_b = '0; e_op = '0; e_crc = '0; e_err = 4'b1000;
    check_pkt("frame");
    drive_bit(1'b1);
    drive_bit(1'b1);
    fill_random(8);
    crc = good_crc(3'b101);
    expect_pkt(3'b101, crc);
    send_pkt(3'b101, crc);
    check_pkt("after_frame");

    fill_random(8);
    crc = good_crc(3'b010);
    expect_pkt(3'b010, crc);
    send_pkt(3'b010, crc);
    check_pkt("bad_op");

    for (int k = 0; k < 6; k++) begin
      n = ($urandom_range(0, 2) != 0) ? 8 : $urandom_range(7, 9);
      fill_random(n);
      op  = 3'($urandom_range(0, 7));
      crc = (n == 8) ? good_crc(op) : 4'($urandom);
      if ($urandom_range(0, 2) == 0) crc = crc ^ 4'($urandom_range(1, 15));
      expect_pkt(op, crc);
      send_pkt(op, crc);
      check_pkt($sformatf("rand%0d", k));
    end

    // Overrun: second packet must be dropped while the first is held
    out_ready = 1'b0;
    fill_random(8);
    crc = good_crc(3'b100);
    expect_pkt(3'b100, crc);
    send_pkt(3'b100, crc);
    check_pkt("ovr_first");
    h_a = e_a; h_b = e_b; h_op = e_op; h_crc = e_crc; h_err = e_err;
    drive_bit(1'b1);
    drive_bit(1'b1);
    fill_random(8);
    send_pkt(3'b001, good_crc(3'b001));
    repeat (4) @(negedge clk);
    chk("ovr valid", 64'(out_valid), 64'd1);
    chk("ovr held", {out_a, out_b}, {h_a, h_b});
    chk("ovr held fields", 64'({out_op, out_crc, err_frame, err_data, err_op, err_crc}),
        64'({h_op, h_crc, h_err}));
    chk("ovr flag", 64'(overrun), 64'd1);
    out_ready = 1'b1;
    @(negedge clk);
    chk("ovr accepted", 64'(out_valid), 64'd0);
    chk("ovr sticky", 64'(overrun), 64'd1);

    // Reset mid-packet after 4 data bytes
    fill_random(4);
    send_data();
    @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_zero("mid_reset");
    rst_n = 1'b1;
    drive_bit(1'b1);
    drive_bit(1'b1);
    fill_random(8);
    crc = good_crc(3'b000);
    expect_pkt(3'b000, crc);
    send_pkt(3'b000, crc);
    check_pkt("post_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
